// File: rtl/lcd_text_writer.sv
// lcd_text_writer: command sequencer in front of the character-LCD controller.
// Holds a 2x16 character buffer and, on request, streams the 34 commands that
// repaint the display (line-1 address, 16 chars, line-2 address, 16 chars),
// spacing commands by CMD_GAP idle cycles so each controller write completes.
// Optional feature macro: LCD_TEXT_AUTOREFRESH_EN (any buffer write schedules
// a refresh without needing refresh_req).
module lcd_text_writer #(
    parameter int         CMD_GAP    = 1300,
    parameter logic [7:0] LINE2_ADDR = 8'hC0,
    parameter logic [7:0] LINE1_ADDR = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_char,
    input  logic       refresh_req,
    input  logic       lcd_busy,
    output logic       lcd_enable,
    output logic [9:0] lcd_bus,
    output logic       writer_busy,
    output logic       done
);

    localparam int               GAP_W    = $clog2(CMD_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CMD_GAP);
    localparam logic [5:0]       LAST_SEQ = 6'd33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [5:0]       seq, seq_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic             pending, pending_nxt;
    logic             enable_nxt;
    logic [9:0]       bus_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             auto_start;
    logic [9:0]       cmd_word;
    logic [7:0]       char_buf [32];

    // Character buffer: writes accepted in every state; reset fills with spaces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                char_buf[i] <= 8'h20;
            end
        end else if (wr_en) begin
            char_buf[wr_addr] <= wr_char;
        end
    end

`ifdef LCD_TEXT_AUTOREFRESH_EN
    logic dirty;
    logic leave_idle;

    assign leave_idle = (state == IDLE) && (state_nxt == ISSUE);

    // Dirty flag: a write always wins over the clear so a write landing on the
    // refresh-start cycle still gets its own follow-up refresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty <= 1'b0;
        end else if (wr_en) begin
            dirty <= 1'b1;
        end else if (leave_idle) begin
            dirty <= 1'b0;
        end
    end

    assign auto_start = dirty;
`else
    assign auto_start = 1'b0;
`endif

    // Command word for the current sequence index; reads the buffer before any
    // same-cycle write lands, so a colliding write sends the old character.
    always_comb begin
        cmd_word = {2'b00, LINE1_ADDR};
        if (seq == 6'd0) begin
            cmd_word = {2'b00, LINE1_ADDR};
        end else if (seq <= 6'd16) begin
            cmd_word = {2'b10, char_buf[5'(seq - 6'd1)]};
        end else if (seq == 6'd17) begin
            cmd_word = {2'b00, LINE2_ADDR};
        end else begin
            cmd_word = {2'b10, char_buf[5'(seq - 6'd2)]};
        end
    end

    // Next-state and registered-output logic for the IDLE/ISSUE/GAP sequencer.
    always_comb begin
        state_nxt   = state;
        seq_nxt     = seq;
        gap_nxt     = gap_cnt;
        enable_nxt  = 1'b0;
        bus_nxt     = lcd_bus;
        busy_nxt    = writer_busy;
        done_nxt    = 1'b0;
        // Requests arriving mid-refresh coalesce into a single pending flag.
        pending_nxt = pending | (refresh_req & writer_busy);

        case (state)
            IDLE: begin
                if (refresh_req || pending || auto_start) begin
                    pending_nxt = 1'b0;
                    seq_nxt     = 6'd0;
                    busy_nxt    = 1'b1;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                // Waiting here also absorbs the controller's power-up init.
                if (!lcd_busy) begin
                    enable_nxt = 1'b1;
                    bus_nxt    = cmd_word;
                    gap_nxt    = GAP_LOAD;
                    state_nxt  = GAP;
                end
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end else if (!lcd_busy) begin
                    if (seq == LAST_SEQ) begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        seq_nxt   = seq + 6'd1;
                        state_nxt = ISSUE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset abandons any refresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            seq         <= 6'd0;
            gap_cnt     <= '0;
            pending     <= 1'b0;
            lcd_enable  <= 1'b0;
            lcd_bus     <= 10'd0;
            writer_busy <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            seq         <= seq_nxt;
            gap_cnt     <= gap_nxt;
            pending     <= pending_nxt;
            lcd_enable  <= enable_nxt;
            lcd_bus     <= bus_nxt;
            writer_busy <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Testbench for lcd_text_writer with a short command gap.
module tb_lcd_text_writer;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [7:0] wr_char = 8'd0;
    logic       refresh_req = 1'b0;
    logic       lcd_busy = 1'b0;
    logic       lcd_enable;
    logic [9:0] lcd_bus;
    logic       writer_busy;
    logic       done;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [9:0] cmds[$];
    int         times[$];
    int         done_times[$];
    logic [7:0] mdl [32];

    typedef struct {
        logic [4:0] addr;
        logic [7:0] ch;
        int         pos;
        logic [9:0] exp_bus;
    } vec_t;

    vec_t vecs [6];

    lcd_text_writer #(
        .CMD_GAP   (GAP),
        .LINE2_ADDR(8'hC0),
        .LINE1_ADDR(8'h80)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .refresh_req(refresh_req),
        .lcd_busy   (lcd_busy),
        .lcd_enable (lcd_enable),
        .lcd_bus    (lcd_bus),
        .writer_busy(writer_busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every command strobe and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (lcd_enable === 1'b1) begin
            cmds.push_back(lcd_bus);
            times.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_times.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        cmds.delete();
        times.delete();
        done_times.delete();
    endtask

    task automatic pulse_refresh();
        refresh_req = 1'b1;
        tick();
        refresh_req = 1'b0;
    endtask

    task automatic write_char(input logic [4:0] a, input logic [7:0] c);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_char = c;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int k = 0;
        while (done_times.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, done_times.size(), n);
    endtask

    task automatic wait_cmds(input int n, input int budget, input string name);
        int k = 0;
        while (cmds.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, cmds.size(), n);
    endtask

    function automatic logic [9:0] exp_cmd(input int i);
        if (i == 0)       return 10'h080;
        else if (i <= 16) return {2'b10, mdl[i-1]};
        else if (i == 17) return 10'h0C0;
        else              return {2'b10, mdl[i-2]};
    endfunction

    // Compare one full 34-command refresh starting at log entry base.
    task automatic check_refresh(input int base, input string name);
        if (cmds.size() < base + 34) begin
            check({name, "_len"}, cmds.size(), base + 34);
        end else begin
            for (int i = 0; i < 34; i++) begin
                check($sformatf("%s_cmd%0d", name, i), cmds[base+i], exp_cmd(i));
            end
            for (int i = 1; i < 34; i++) begin
                check($sformatf("%s_space%0d", name, i), times[base+i] - times[base+i-1], GAP + 2);
            end
        end
    endtask

    initial begin
        int c0;

        vecs[0] = '{5'd0,  8'h41, 1,  10'h241};
        vecs[1] = '{5'd31, 8'h42, 33, 10'h242};
        vecs[2] = '{5'd15, 8'h5A, 16, 10'h25A};
        vecs[3] = '{5'd16, 8'h30, 18, 10'h230};
        vecs[4] = '{5'd7,  8'h7E, 8,  10'h27E};
        vecs[5] = '{5'd23, 8'h61, 25, 10'h261};
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;

        // Reset state, asynchronously visible.
        #1;
        check("rst_enable", lcd_enable, 1'b0);
        check("rst_bus", lcd_bus, 10'h000);
        check("rst_busy", writer_busy, 1'b0);
        check("rst_done", done, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Plain refresh of a blank buffer.
        clear_log();
        c0 = cyc;
        pulse_refresh();
        wait_done(1, 400, "t1_done");
        check("t1_busy_after_done", writer_busy, 1'b0);
        check("t1_ncmds", cmds.size(), 34);
        if (times.size() > 0) check("t1_first_latency", times[0] - c0, 2);
        check_refresh(0, "t1");
        if (times.size() >= 34 && done_times.size() >= 1)
            check("t1_done_latency", done_times[0] - times[33], GAP + 1);
        tick(10);
        check("t1_single_done", done_times.size(), 1);

        // Table-driven buffer writes then a refresh.
        for (int i = 0; i < 6; i++) begin
            write_char(vecs[i].addr, vecs[i].ch);
            mdl[vecs[i].addr] = vecs[i].ch;
        end
        clear_log();
        pulse_refresh();
        wait_done(1, 400, "t2_done");
        for (int i = 0; i < 6; i++) begin
            if (cmds.size() > vecs[i].pos)
                check($sformatf("t2_vec%0d", i), cmds[vecs[i].pos], vecs[i].exp_bus);
            else
                check($sformatf("t2_vec%0d_len", i), cmds.size(), 34);
        end
        check_refresh(0, "t2");

        // Controller busy holds off the first command.
        clear_log();
        lcd_busy = 1'b1;
        pulse_refresh();
        tick(100);
        check("t3_no_cmd_while_busy", cmds.size(), 0);
        check("t3_writer_busy", writer_busy, 1'b1);
        lcd_busy = 1'b0;
        wait_done(1, 400, "t3_done");
        check("t3_ncmds", cmds.size(), 34);
        if (cmds.size() > 0) check("t3_first_cmd", cmds[0], 10'h080);

        // Two requests mid-refresh coalesce into one extra refresh.
        clear_log();
        pulse_refresh();
        tick(50);
        pulse_refresh();
        tick(30);
        pulse_refresh();
        wait_done(2, 800, "t4_done2");
        check("t4_ncmds", cmds.size(), 68);
        if (times.size() > 34 && done_times.size() >= 1)
            check("t4_restart_latency", times[34] - done_times[0], 2);
        check_refresh(34, "t4b");
        tick(60);
        check("t4_no_third_done", done_times.size(), 2);
        check("t4_no_third_cmds", cmds.size(), 68);

        // Reset in the middle of a refresh.
        clear_log();
        pulse_refresh();
        wait_cmds(11, 200, "t5_reach_seq10");
        check("t5_enable_before_rst", lcd_enable, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_enable", lcd_enable, 1'b0);
        check("t5_rst_busy", writer_busy, 1'b0);
        check("t5_rst_bus", lcd_bus, 10'h000);
        tick(2);
        rst_n = 1'b1;
        clear_log();
        tick(40);
        check("t5_no_resume", cmds.size(), 0);
        check("t5_no_done", done_times.size(), 0);
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        pulse_refresh();
        wait_done(1, 400, "t5_done");
        check_refresh(0, "t5");

`ifdef LCD_TEXT_AUTOREFRESH_EN
        // A write alone starts a refresh; a write during it schedules one more.
        clear_log();
        write_char(5'd3, 8'h33);
        mdl[3] = 8'h33;
        wait_cmds(5, 100, "t6_auto_start");
        write_char(5'd4, 8'h44);
        mdl[4] = 8'h44;
        wait_done(2, 800, "t6_done2");
        check("t6_ncmds", cmds.size(), 68);
        check_refresh(34, "t6b");
        tick(60);
        check("t6_no_third", done_times.size(), 2);
`else
        // Without auto-refresh a write alone starts nothing.
        clear_log();
        write_char(5'd3, 8'h33);
        mdl[3] = 8'h33;
        tick(40);
        check("t6_no_auto_cmds", cmds.size(), 0);
        check("t6_no_auto_busy", writer_busy, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
